// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Up/down modulo-MODULUS counter with an enable prescaler, a synchronous
//   load and a registered terminal-count pulse.
//
//   Compile-time option:
//     MOD_COUNTER_SAT_EN  undefined (default): the count wraps at its limits
//                         and tc pulses on the cycle after each wrap.
//                         defined: the count saturates at its limits and tc
//                         is high after every step attempted at the limit.
//
//   rst is asynchronous and active-high. Its deassertion must already be
//   synchronised to clk by the surrounding logic.
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int     WIDTH    = 6,
  parameter longint MODULUS  = 16,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  // ---------------------------------------------------------------------------
  // Parameter legality, rejected while the design is elaborated
  // ---------------------------------------------------------------------------
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH must lie in 1..32");
  end

  if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
    $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
  end

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("mod_counter: PRESCALE must lie in 1..65535");
  end

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // Limit compares run one bit wider than the count so MODULUS = 2**WIDTH is
  // representable and the increment never overflows.
  localparam int XW = WIDTH + 1;

  // A single-state prescaler still needs a one-bit register to stay legal.
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [XW-1:0]    MOD_X  = XW'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MODULUS - 1);
  localparam logic [PS_W-1:0]  PS_MAX = PS_W'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q,    ps_d;
  logic             tc_q,    tc_d;

  // Internal decode
  logic             step;
  logic [XW-1:0]    cnt_x;
  logic [XW-1:0]    inc_x;
  logic [XW-1:0]    lv_x;
  logic             at_max;
  logic             at_zero;
  logic             lv_too_big;

  // Widened views of the count and load value for overflow-free compares.
  assign cnt_x      = {1'b0, count_q};
  assign inc_x      = cnt_x + XW'(1);
  assign lv_x       = {1'b0, load_val};
  assign at_max     = (inc_x == MOD_X);
  assign at_zero    = (count_q == '0);
  assign lv_too_big = (lv_x >= MOD_X);

  // A step is taken on the enabled, non-load cycle that completes a prescale.
  assign step = en && !load && (ps_q == PS_MAX);

  // Prescaler next state: cleared by load, advanced by en, held otherwise.
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // through the branches below leaves it unassigned and infers a latch.
    ps_d = ps_q;
    if (load) begin
      ps_d = '0;
    end else if (en) begin
      if (ps_q == PS_MAX) begin
        ps_d = '0;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  // Count and terminal-count next state: load wins, then a step in the
  // sampled direction, otherwise hold with tc low.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = lv_too_big ? MAX_W : load_val;
    end else if (step) begin
      if (up) begin
        if (at_max) begin
`ifdef MOD_COUNTER_SAT_EN
          count_d = count_q;
`else
          count_d = '0;
`endif
          tc_d    = 1'b1;
        end else begin
          count_d = inc_x[WIDTH-1:0];
        end
      end else begin
        if (at_zero) begin
`ifdef MOD_COUNTER_SAT_EN
          count_d = count_q;
`else
          count_d = MAX_W;
`endif
          tc_d    = 1'b1;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // State register with asynchronous clear of count, prescaler and tc.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops take non-blocking assignments so every register samples the
    // pre-edge values of the others regardless of evaluation order.
    if (rst) begin
      count_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
    end
  end

  // Outputs come straight from flops; no input reaches them combinationally.
  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
//   Three instances share one stimulus stream:
//     u0 : defaults               (WIDTH=6, MODULUS=16, PRESCALE=1)
//     u1 : prescaled              (WIDTH=6, MODULUS=16, PRESCALE=3)
//     u2 : full-range modulus     (WIDTH=4, MODULUS=16 = 2**WIDTH)
//   A behavioural model predicts each instance; predictions are queued when
//   the stimulus is driven and popped after the clock edge that applies it.
//   Define MOD_COUNTER_SAT_EN for both RTL and bench to exercise saturation.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  localparam int N = 3;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [5:0] lv;

  logic [5:0] count0, count1;
  logic [3:0] count2;
  logic       tc0, tc1, tc2;

  mod_counter #(.WIDTH(6), .MODULUS(16), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv), .count(count0), .tc(tc0)
  );

  mod_counter #(.WIDTH(6), .MODULUS(16), .PRESCALE(3)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv), .count(count1), .tc(tc1)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .count(count2), .tc(tc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance configuration seen by the model.
  int cfg_w   [N] = '{6, 6, 4};
  int cfg_mod [N] = '{16, 16, 16};
  int cfg_pre [N] = '{1, 3, 1};

  // Model state.
  int m_cnt [N];
  int m_ps  [N];

  typedef struct {
    int c0, c1, c2;
    int t0, t1, t2;
  } exp_t;

  exp_t sb [$];

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference for one clock of instance i.
  task automatic model_step(input int i, input logic e, input logic u, input logic l,
                            input int v, output int tc_o);
    int lvm;
    lvm  = v & ((1 << cfg_w[i]) - 1);
    tc_o = 0;
    if (l) begin
      m_cnt[i] = (lvm >= cfg_mod[i]) ? cfg_mod[i] - 1 : lvm;
      m_ps[i]  = 0;
    end else if (e) begin
      if (m_ps[i] == cfg_pre[i] - 1) begin
        m_ps[i] = 0;
        if (u) begin
          if (m_cnt[i] == cfg_mod[i] - 1) begin
`ifndef MOD_COUNTER_SAT_EN
            m_cnt[i] = 0;
`endif
            tc_o = 1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end else begin
          if (m_cnt[i] == 0) begin
`ifndef MOD_COUNTER_SAT_EN
            m_cnt[i] = cfg_mod[i] - 1;
`endif
            tc_o = 1;
          end else begin
            m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end else begin
        m_ps[i] = m_ps[i] + 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_ps[i]  = 0;
    end
  endtask

  // Drive one cycle of stimulus, queue the prediction, then compare after the edge.
  task automatic cycle(input logic e, input logic u, input logic l, input int v);
    exp_t x;
    exp_t got;
    int   t;
    en   = e;
    up   = u;
    load = l;
    lv   = 6'(v);
    model_step(0, e, u, l, v, t); x.c0 = m_cnt[0]; x.t0 = t;
    model_step(1, e, u, l, v, t); x.c1 = m_cnt[1]; x.t1 = t;
    model_step(2, e, u, l, v, t); x.c2 = m_cnt[2]; x.t2 = t;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("u0_count", 32'(count0), 32'(got.c0));
      check("u0_tc",    32'(tc0),    32'(got.t0));
      check("u1_count", 32'(count1), 32'(got.c1));
      check("u1_tc",    32'(tc1),    32'(got.t1));
      check("u2_count", 32'(count2), 32'(got.c2));
      check("u2_tc",    32'(tc2),    32'(got.t2));
    end
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_u0_count"}, 32'(count0), 32'd0);
    check({tag, "_u0_tc"},    32'(tc0),    32'd0);
    check({tag, "_u1_count"}, 32'(count1), 32'd0);
    check({tag, "_u1_tc"},    32'(tc1),    32'd0);
    check({tag, "_u2_count"}, 32'(count2), 32'd0);
    check({tag, "_u2_tc"},    32'(tc2),    32'd0);
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    up   = 1'b1;
    load = 1'b0;
    lv   = '0;
    model_reset();

    // Reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    check_all_clear("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all_clear("post_reset");

    // Free-running count up: wrap 15 -> 0 on u0/u2, prescaled steps on u1.
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b1, 1'b0, 0);

    // Disabled: everything holds, tc low.
    cycle(1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 1'b1, 1'b0, 0);

    // Down from 0 wraps to MODULUS-1 with a tc pulse, then tc drops.
    cycle(1'b0, 1'b0, 1'b1, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 1'b0, 1'b0, 0);

    // Load beats en; oversized value clamps to MODULUS-1; load clears prescaler.
    cycle(1'b1, 1'b1, 1'b1, 40);
    cycle(1'b1, 1'b1, 1'b1, 7);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 0);

    // Direction flips mid-prescale; the step-cycle direction decides.
    cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b0, 0);

    // Behaviour at the upper limit (wrap or saturate), then step back down.
    cycle(1'b0, 1'b1, 1'b1, 15);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 1'b0, 0);

    // Largest load value: 63 clamps on u0/u1, reads as 15 on the 4-bit u2.
    cycle(1'b0, 1'b1, 1'b1, 63);

    // Asynchronous reset between edges, with u0 at 9 and u1 mid-prescale.
    cycle(1'b0, 1'b1, 1'b1, 8);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("pre_rst_u0_count", 32'(count0), 32'd9);
    #2 rst = 1'b1;
    #1;
    check_all_clear("async_rst");

    // Reset held across an edge while a load is pending discards the load.
    en   = 1'b1;
    load = 1'b1;
    lv   = 6'd5;
    @(posedge clk);
    #1;
    check_all_clear("rst_mid_load");
    en   = 1'b0;
    load = 1'b0;
    rst  = 1'b0;
    model_reset();

    // Counting resumes from 0 with a fresh prescale.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter WIDTH, default 6: count width in bits; legal range 1..32.
REQ-002 Parameter MODULUS, default 16: count sequence length; legal range 2..2**WIDTH; an out-of-range value SHALL be a elaboration-time error.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step; legal range 1..65535.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  count enable; qualifies the prescaler.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 count  output  WIDTH  registered count value.
REQ-011 tc  output  1  registered terminal-count pulse.

Function
REQ-012 count SHALL always satisfy count < MODULUS; no other value is reachable.
REQ-013 Prescaler: internal counter 0..PRESCALE-1 that advances on each cycle with en=1 and load=0; a step SHALL occur on the cycle the prescaler equals PRESCALE-1, after which it returns to 0; with PRESCALE=1 every enabled cycle is a step.
REQ-014 en=0 and load=0: count, prescaler hold; tc=0 next cycle.
REQ-015 Step with up=1: count < MODULUS-1 -> count+1; count = MODULUS-1 -> wrap to 0.
REQ-016 Step with up=0: count > 0 -> count-1; count = 0 -> wrap to MODULUS-1.
REQ-017 tc SHALL be 1 for exactly the one cycle following a wrap step (coincident with the wrapped count value), else 0.
REQ-018 Latency: count and tc update one clk edge after the qualifying input cycle; no combinational path from inputs to outputs.
REQ-019 load=1 SHALL take priority over en and up: count <- load_val, or MODULUS-1 when load_val >= MODULUS; prescaler <- 0; tc <- 0.
REQ-020 up changing mid-prescale SHALL NOT reset the prescaler; the direction sampled on the step cycle governs the step.
REQ-021 Arithmetic SHALL be performed at WIDTH+1 bits internally so MODULUS = 2**WIDTH wraps correctly without overflow.

Reset
REQ-022 rst=1 SHALL immediately (no clock needed) force count=0, tc=0, prescaler=0.
REQ-023 rst asserted mid-prescale or mid-load SHALL discard that operation; counting resumes from 0 on the first enabled edge after rst deasserts.
REQ-024 Deassertion of rst is synchronous to clk by the integrating logic; the block adds no synchroniser.

Configuration
REQ-025 Macro MOD_COUNTER_SAT_EN SHALL select the limit behaviour at compile time.
REQ-026 Without MOD_COUNTER_SAT_EN: wrap behaviour per REQ-015..REQ-017.
REQ-027 With MOD_COUNTER_SAT_EN: an up step at MODULUS-1 and a down step at 0 SHALL hold count; tc SHALL be 1 on every cycle in which count sits at the limit in the current direction (MODULUS-1 if up=1, 0 if up=0) and a step was attempted, else 0; load behaviour unchanged.

Verification
REQ-028 Defaults, rst pulse then en=1, up=1 for 20 cycles -> count 0,1..15,0,1,2,3; tc=1 only in the cycle count returns to 0.
REQ-029 Defaults, count=0, up=0, en=1 one cycle -> count=15, tc=1 for one cycle.
REQ-030 PRESCALE=3, en=1, up=1 for 9 cycles from reset -> count steps to 1,2,3 on cycles 3,6,9 only.
REQ-031 load=1, load_val=40 with en=1 (MODULUS=16) -> count=15, tc=0; load_val=7 -> count=7, prescaler cleared.
REQ-032 rst asserted asynchronously between edges at count=9 -> count=0 and tc=0 before the next clk edge.
REQ-033 MOD_COUNTER_SAT_EN defined, count=15, up=1, en=1 for 3 cycles -> count stays 15, tc=1 each cycle; up=0 -> count 14, tc=0.
